// File: rtl/mash_pkg.sv
// Shared constants and helpers for the parametrised MASH delta-sigma modulator.
package mash_pkg;

   localparam int ORDER_MIN = 1;
   localparam int ORDER_MAX = 4;
   localparam int WIDTH_MIN = 8;
   localparam int WIDTH_MAX = 32;

   // Dither generator: x^15 + x^14 + 1, taps on bits 14 and 13.
   localparam int                LFSR_W    = 15;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;

   // Output spans -(2^(order-1)-1) .. 2^(order-1), which needs order+1 signed bits.
   function automatic int out_width(input int order);
      return order + 1;
   endfunction

endpackage

// File: rtl/mash_acc.sv
// One first-order stage of the MASH cascade: WIDTH-bit accumulator that wraps
// modulo 2^WIDTH, with the overflow captured in a registered carry bit.
module mash_acc #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] src,
   input  logic             cin,
   output logic [WIDTH-1:0] acc,
   output logic             carry
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, acc} + {1'b0, src} + {{WIDTH{1'b0}}, cin};

   // NOTE: clocked state uses <= so every stage samples its neighbours' old values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (en) begin
         {carry, acc} <= sum;
      end
   end

endmodule

// File: rtl/mash_nth.sv
// MASH 1-1-..-1 delta-sigma modulator of ORDER stages with aligned carries and
// nested noise cancellation. Optional dither LFSR when MASH_DITHER_EN is defined.
module mash_nth
   import mash_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int ORDER = 3,
   parameter int OUT_W = out_width(ORDER)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic                    clr_i,
   input  logic                    frac_vld_i,
   input  logic [WIDTH-1:0]        x_i,
   output logic signed [OUT_W-1:0] y_o,
   output logic [WIDTH-1:0]        e_o
);

   logic [WIDTH-1:0]        x_q;
   logic [WIDTH-1:0]        acc     [ORDER];
   logic [ORDER-1:0]        carry;
   logic [ORDER-1:0]        aligned;
   logic                    dither;
   logic signed [OUT_W-1:0] d       [ORDER];
   logic signed [OUT_W-1:0] d_q     [ORDER];

   // The frequency word is retuned regardless of enable or clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
      end else if (frac_vld_i) begin
         x_q <= x_i;
      end
   end

`ifdef MASH_DITHER_EN
   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (clr_i) begin
         lfsr <= LFSR_SEED;
      end else if (en_i) begin
         lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign dither = lfsr[0];
`else
   assign dither = 1'b0;
`endif

   for (genvar k = 0; k < ORDER; k++) begin : g_stage
      localparam int DLY = ORDER - 1 - k;
      logic [WIDTH-1:0] src;
      logic             cin;

      if (k == 0) begin : g_head
         assign src = x_q;
         assign cin = dither;
      end else begin : g_tail
         assign src = acc[k-1];
         assign cin = 1'b0;
      end

      mash_acc #(.WIDTH(WIDTH)) u_acc (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en_i),
         .clr   (clr_i),
         .src   (src),
         .cin   (cin),
         .acc   (acc[k]),
         .carry (carry[k])
      );

      // Earlier stages see the input sooner, so their carries wait to line up
      // with the last stage's carry.
      if (DLY == 0) begin : g_nodly
         assign aligned[k] = carry[k];
      end else begin : g_dly
         logic [DLY-1:0] dly;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dly <= '0;
            end else if (clr_i) begin
               dly <= '0;
            end else if (en_i) begin
               dly[0] <= carry[k];
               for (int j = 1; j < DLY; j++) begin
                  dly[j] <= dly[j-1];
               end
            end
         end

         assign aligned[k] = dly[DLY-1];
      end
   end

   // d[k] = aligned[k] + (1 - z^-1) d[k+1], innermost level first.
   // NOTE: every d entry gets a default before the loop, so no latch can form.
   always_comb begin
      for (int k = 0; k < ORDER; k++) begin
         d[k] = '0;
      end
      d[ORDER-1] = signed'(OUT_W'(aligned[ORDER-1]));
      for (int k = ORDER - 2; k >= 0; k--) begin
         d[k] = signed'(OUT_W'(aligned[k])) + d[k+1] - d_q[k+1];
      end
   end

   // d_q[k] holds the previous d[k]; d_q[0] doubles as the output register.
   // NOTE: this small register array is reset entry by entry, unlike a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ORDER; k++) begin
            d_q[k] <= '0;
         end
      end else if (clr_i) begin
         for (int k = 0; k < ORDER; k++) begin
            d_q[k] <= '0;
         end
      end else if (en_i) begin
         for (int k = 0; k < ORDER; k++) begin
            d_q[k] <= d[k];
         end
      end
   end

   assign y_o = d_q[0];
   assign e_o = acc[ORDER-1];

endmodule

// File: tb/tb_mash_nth.sv
// Bench for mash_nth: ORDER 1, 3 and 4 instances share stimulus and are checked
// each cycle against a carry-history model plus running-sum error bounds.
module tb_mash_nth;

   localparam int     W    = 24;
   localparam int     NDUT = 3;
   localparam int     ORD [NDUT] = '{1, 3, 4};
   localparam longint MOD  = longint'(1) << W;

   logic         clk        = 1'b0;
   logic         rst_n      = 1'b0;
   logic         en_i       = 1'b0;
   logic         clr_i      = 1'b0;
   logic         frac_vld_i = 1'b0;
   logic [W-1:0] x_i        = '0;

   logic signed [1:0] y1;
   logic signed [3:0] y3;
   logic signed [4:0] y4;
   logic [W-1:0]      e1, e3, e4;

   mash_nth #(.WIDTH(W), .ORDER(1)) u_o1 (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i),
      .frac_vld_i(frac_vld_i), .x_i(x_i), .y_o(y1), .e_o(e1)
   );
   mash_nth #(.WIDTH(W), .ORDER(3)) u_o3 (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i),
      .frac_vld_i(frac_vld_i), .x_i(x_i), .y_o(y3), .e_o(e3)
   );
   mash_nth #(.WIDTH(W), .ORDER(4)) u_o4 (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i),
      .frac_vld_i(frac_vld_i), .x_i(x_i), .y_o(y4), .e_o(e4)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input longint v,
                              input longint lo, input longint hi);
      checks++;
      if (v < lo || v > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected within [%0d,%0d] (time %0t)",
                  name, v, lo, hi, $time);
      end
   endtask

   function automatic longint dut_y(input int d);
      case (d)
         0:       return longint'(y1);
         1:       return longint'(y3);
         default: return longint'(y4);
      endcase
   endfunction

   function automatic longint dut_e(input int d);
      case (d)
         0:       return longint'(e1);
         1:       return longint'(e3);
         default: return longint'(e4);
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   // Each stage is plain modular arithmetic; the output is the binomial sum
   // y[t] = sum_k (1 - z^-1)^(k-1) c_k[t-1-(ORDER-k)] over stored carry history.
   longint macc  [NDUT][4];
   bit     chist [NDUT][4][64];
   int     t_cnt = 0;
   longint mxq   = 0;
   longint exp_y [NDUT];
   longint exp_e [NDUT];

   function automatic int binom(input int n, input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   function automatic int hist(input int d, input int k, input int t);
      if (t < 1) return 0;
      return int'(chist[d][k][t % 64]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      longint old [4];
      longint s, ym, term;
      int     o;
      if (!rst_n) begin
         mxq   = 0;
         t_cnt = 0;
         for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 4; k++) macc[d][k] = 0;
            exp_y[d] = 0;
            exp_e[d] = 0;
         end
      end else begin
         if (clr_i) begin
            t_cnt = 0;
            for (int d = 0; d < NDUT; d++) begin
               for (int k = 0; k < 4; k++) macc[d][k] = 0;
               exp_y[d] = 0;
               exp_e[d] = 0;
            end
         end else if (en_i) begin
            t_cnt++;
            for (int d = 0; d < NDUT; d++) begin
               o   = ORD[d];
               old = macc[d];
               for (int k = 0; k < o; k++) begin
                  s = old[k] + ((k == 0) ? mxq : old[k-1]);
                  chist[d][k][t_cnt % 64] = (s >= MOD);
                  macc[d][k] = s % MOD;
               end
               exp_e[d] = macc[d][o-1];
               ym = 0;
               for (int k = 1; k <= o; k++) begin
                  for (int j = 0; j < k; j++) begin
                     term = binom(k - 1, j) * hist(d, k - 1, t_cnt - 1 - (o - k) - j);
                     ym  += (j % 2 == 1) ? -term : term;
                  end
               end
               exp_y[d] = ym;
            end
         end
         if (frac_vld_i) mxq = longint'(x_i);
      end
   end

   // ---------------- per-cycle comparison ----------------
   bit     sum_en = 1'b0;
   longint seg_x  = 0;
   longint ysum [NDUT];
   int     last_t = 0;

   always @(negedge clk) begin
      longint n, err, bnd;
      if (t_cnt != last_t) begin
         for (int d = 0; d < NDUT; d++) begin
            if (t_cnt == last_t + 1) ysum[d] += dut_y(d);
            else                     ysum[d] = 0;
         end
         last_t = t_cnt;
      end
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("y_o order%0d t=%0d", ORD[d], t_cnt), dut_y(d), exp_y[d]);
         check($sformatf("e_o order%0d t=%0d", ORD[d], t_cnt), dut_e(d), exp_e[d]);
         check_range($sformatf("y_o range order%0d", ORD[d]), dut_y(d),
                     -((longint'(1) << (ORD[d] - 1)) - 1), longint'(1) << (ORD[d] - 1));
         if (sum_en) begin
            n   = (t_cnt > ORD[d]) ? longint'(t_cnt - ORD[d]) : 0;
            err = ysum[d] * MOD - n * seg_x;
            bnd = (longint'(1) << (ORD[d] - 1)) * MOD;
            check_range($sformatf("sum error*2^24 order%0d t=%0d", ORD[d], t_cnt),
                        err, -bnd, bnd);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seg(input logic [W-1:0] x, input bit chk_sum);
      sum_en     = 1'b0;
      seg_x      = longint'(x);
      clr_i      = 1'b1;
      frac_vld_i = 1'b1;
      x_i        = x;
      en_i       = 1'b1;
      tick();
      clr_i      = 1'b0;
      frac_vld_i = 1'b0;
      sum_en     = chk_sum;
   endtask

   initial begin
      int ones;
      for (int d = 0; d < NDUT; d++) ysum[d] = 0;

      repeat (2) tick();
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset y_o order%0d", ORD[d]), dut_y(d), 0);
         check($sformatf("reset e_o order%0d", ORD[d]), dut_e(d), 0);
      end
      rst_n = 1'b1;
      tick();

      // Half-scale word on the first-order stage: 0,1 alternation.
      start_seg(24'h800000, 1'b1);
      tick();
      check("o1 x=800000 t1 e_o", longint'(e1), 24'h800000);
      check("o1 x=800000 t1 y_o", longint'(y1), 0);
      tick();
      check("o1 x=800000 t2 e_o", longint'(e1), 0);
      check("o1 x=800000 t2 y_o", longint'(y1), 0);
      tick();
      check("o1 x=800000 t3 y_o", longint'(y1), 1);
      check("o1 x=800000 t3 e_o", longint'(e1), 24'h800000);
      tick();
      check("o1 x=800000 t4 y_o", longint'(y1), 0);
      repeat (16) tick();

      // Quarter-scale word: one pulse every four cycles, 2500 in 10000.
      start_seg(24'h400000, 1'b1);
      ones = 0;
      for (int i = 1; i <= 10001; i++) begin
         tick();
         if (i >= 2 && y1 == 2'sd1) ones++;
         if (i == 4) check("o1 x=400000 t4 y_o", longint'(y1), 0);
         if (i == 5) check("o1 x=400000 t5 y_o", longint'(y1), 1);
      end
      check("o1 x=400000 ones in 10000", ones, 2500);

      // Just below half scale, with a 50-cycle enable gap in the middle.
      start_seg(24'h7FFFFF, 1'b1);
      repeat (5000) tick();
      en_i = 1'b0;
      repeat (50) tick();
      en_i = 1'b1;
      repeat (5000) tick();

      // Clear and retune on the same edge.
      start_seg(24'h200000, 1'b1);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("clr+vld y_o order%0d", ORD[d]), dut_y(d), 0);
         check($sformatf("clr+vld e_o order%0d", ORD[d]), dut_e(d), 0);
      end
      repeat (100) tick();

      // Asynchronous reset pulse mid-run; x_q returns to zero as well.
      sum_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("async reset y_o order%0d", ORD[d]), dut_y(d), 0);
         check($sformatf("async reset e_o order%0d", ORD[d]), dut_e(d), 0);
      end
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("after reset x_q=0 y_o order4", longint'(y4), 0);
      check("after reset x_q=0 e_o order4", longint'(e4), 0);
      start_seg(24'h200000, 1'b1);
      repeat (300) tick();

      // Smallest nonzero word.
      start_seg(24'h000001, 1'b1);
      repeat (8000) tick();

      // Randomised retunes, enable gaps and clears.
      sum_en = 1'b0;
      repeat (3000) begin
         en_i       = ($urandom_range(3) != 0);
         frac_vld_i = ($urandom_range(19) == 0);
         clr_i      = ($urandom_range(99) == 0);
         x_i        = W'($urandom);
         tick();
      end
      en_i       = 1'b1;
      clr_i      = 1'b0;
      frac_vld_i = 1'b0;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mash_nth.md
# mash_nth

Parametrised MASH delta-sigma modulator, successor to the fixed 1-1-1 modulator: ORDER cascaded first-order accumulators (1..4) with pipelined noise cancellation. It drives the integer-offset input of the fractional-N divider with a signed sequence whose long-run mean equals x/2^WIDTH. A frac-update strobe, a clock-enable and a synchronous clear are provided so the divider controller can retune without glitches.

## Interface
- WIDTH, 24: accumulator and fractional-word width (8..32)
- ORDER, 3: number of cascaded stages (1..4)
- OUT_W, ORDER+1: output width, signed
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  clock enable; low = all state held
- clr_i  in  1  synchronous clear of accumulators and cancellation pipeline
- frac_vld_i  in  1  strobe: latch x_i into x_q
- x_i  in  WIDTH  unsigned fractional word
- y_o  out  OUT_W  signed modulator output
- e_o  out  WIDTH  last-stage accumulator residual (acc_ORDER)

## Operation
- x_q: loaded from x_i on any edge with frac_vld_i=1, independent of en_i and clr_i.
- Stage k (1..ORDER), when en_i=1: {c_k, acc_k} <= acc_k + src_k, unsigned WIDTH-bit, c_k = carry-out (1 bit, registered). src_1 = x_q; src_k = acc_{k-1} (registered value).
- Alignment: c_k passes through ORDER-k delay registers, so all carries reaching cancellation share one time index.
- Cancellation (nested, registered per level): d_ORDER = c_ORDER; d_k = c_k + d_{k+1} - d_{k+1}[n-1]; y_o <= d_1, signed OUT_W.
- Output range: -(2^(ORDER-1)-1) .. 2^(ORDER-1); ORDER=1 gives 0/1 only.
- clr_i=1 (takes priority over en_i): all acc_k, c_k, delay and cancellation registers, y_o and e_o <= 0; x_q unaffected.
- en_i=0 and clr_i=0: no register other than x_q changes.
- Transfer: Y = z^-L X/2^WIDTH + (1-z^-1)^ORDER E.

## Timing
- Reset: acc_k, c_k, all pipeline regs, x_q, y_o, e_o = 0.
- Latency: frac_vld_i at edge 0 -> x_q edge 0 -> c_1 edge 1 -> first effect on y_o at edge L = ORDER+1 (counting enabled edges only after edge 0).
- e_o equals acc_ORDER, updated the same edge as the accumulator.
- Accumulator wrap modulo 2^WIDTH is the carry mechanism; no saturation anywhere.
- clr_i and frac_vld_i on the same edge: state cleared and new x_q loaded; next enabled edge starts from zero with the new word.
- Reset deassertion mid-operation: restart as from clear; first nonzero y_o no earlier than edge L.

## Configuration
- MASH_DITHER_EN defined: 15-bit LFSR (x^15+x^14+1, seed 15'h0001, reset to seed, advances on enabled edges, cleared to seed by clr_i); its bit 0 added at LSB of stage-1 sum (src_1 = x_q + lfsr[0]). Mean bias 0.5 LSB, breaks limit cycles.
- Not defined: no LFSR logic; output fully deterministic for a given x_q.

## Structure
- Package mash_pkg: OUT_W calculation function, LFSR polynomial/seed constants, ORDER/WIDTH legal-range constants.
- Sub-module mash_acc: one stage (WIDTH-bit register, carry register, en/clr), instantiated ORDER times via generate.
- Top holds x_q, carry-delay lines, nested cancellation, optional LFSR.

## Test plan
- ORDER=1, WIDTH=24, x=24'h800000, dither off -> y_o alternates 0,1 after latency 2; e_o alternates 24'h800000, 0.
- ORDER=1, x=24'h400000 -> y_o repeats 0,0,0,1; exactly 2500 ones in 10000 cycles.
- ORDER=3, x=24'h7FFFFF (2^23-1), 10000 cycles -> y_o within [-3,4]; |sum(y_o) - n*x/2^24| <= 4 at every n.
- ORDER=4, x=24'h000001 -> y_o within [-7,8]; running-sum error bound <= 8; first 1 in c_1 after 2^24 enabled cycles.
- en_i low 50 cycles mid-run -> y_o, e_o frozen; sequence resumes identical to an uninterrupted run shifted by 50.
- clr_i with simultaneous frac_vld_i (x=24'h200000), and rst_n pulse mid-run -> all outputs 0 next edge, then sequence matches fresh-start golden model for new x.
